// File: rtl/delay_align_checker.sv
// Delay-line receive checker: searches for the source-to-delayed offset,
// locks onto it, then counts and flags mismatches while tracking.
module delay_align_checker #(
  parameter int D      = 7,
  parameter int SEL_W  = 3,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [D-1:0]     src_data,
  input  logic [D-1:0]     dly_data,
  output logic             lock,
  output logic [SEL_W-1:0] delay_est,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int DEPTH = 2 ** SEL_W;
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [D-1:0]     hist_q [DEPTH-1];
  logic [1:0]       state_q, state_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [SEL_W-1:0] fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             errp_q, errp_d;
  logic [ERR_W-1:0] errc_q, errc_d;

  logic [SEL_W-1:0] sel;
  logic [D-1:0]     ref_data;
  logic             hit;

  // Candidate 0 is the live source; k>0 looks k samples back.
  always_comb begin
    sel = (state_q == S_LOCKED) ? dest_q : cand_q;
    ref_data = src_data;
    for (int k = 1; k < DEPTH; k++) begin
      if (sel == SEL_W'(k)) ref_data = hist_q[k-1];
    end
    hit = (dly_data == ref_data);
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    dest_d  = dest_q;
    cand_d  = cand_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    errp_d  = 1'b0;
    errc_d  = errc_q;
    if (src_valid) begin
      case (state_q)
        S_FILL: begin
          if (fill_q == SEL_W'(DEPTH - 2)) begin
            state_d = S_SEARCH;
            cand_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        S_SEARCH: begin
          if (hit) begin
            if (match_q == MW'(LOCK_N - 1)) begin
              dest_d  = cand_q;
              lock_d  = 1'b1;
              state_d = S_LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            cand_d  = cand_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (hit) begin
            miss_d = '0;
          end else begin
            errp_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + 1'b1;
            if (miss_q == LW'(LOSS_N - 1)) begin
              lock_d  = 1'b0;
              state_d = S_SEARCH;
              cand_d  = dest_q + 1'b1;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH - 1; k++) hist_q[k] <= '0;
      state_q <= S_FILL;
      lock_q  <= 1'b0;
      dest_q  <= '0;
      cand_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      errp_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      if (src_valid) begin
        hist_q[0] <= src_data;
        for (int k = 1; k < DEPTH - 1; k++) hist_q[k] <= hist_q[k-1];
      end
      state_q <= state_d;
      lock_q  <= lock_d;
      dest_q  <= dest_d;
      cand_q  <= cand_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      errp_q  <= errp_d;
      errc_q  <= errc_d;
    end
  end

  assign lock      = lock_q;
  assign delay_est = dest_q;
  assign state     = state_q;
  assign err_pulse = errp_q;
  assign err_cnt   = errc_q;

endmodule
